// File: rtl/ets_multich_sampler.sv
// Multi-channel equivalent-time sampling core.
// For each MMCM phase step the core counts comparator ones per channel over a
// programmable number of triggers, writes one count per channel to a result
// buffer, then requests a phase shift and waits for the MMCM to finish.
// Outputs are driven from registers: wr_*, ps_en and busy are loaded with the
// values belonging to the next state, so each one is valid in the cycle that
// its state is active.
module ets_multich_sampler #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int PHASE_W = 10,
  parameter int ADDR_W  = 12,
  parameter int TMO_W   = 12
) (
  input  logic               shifting_clk,
  input  logic               S_AXI_DATA_aresetn,
  input  logic [NCH-1:0]     cmp_data,
  input  logic               trig_in,
  input  logic               start,
  input  logic               abort,
  input  logic               dir,
  input  logic [CNT_W-1:0]   avg_count,
  input  logic [PHASE_W-1:0] phase_steps,
  output logic               ps_en,
  output logic               ps_incdec,
  input  logic               ps_done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [CNT_W-1:0]   wr_data,
  output logic [PHASE_W-1:0] phase_idx,
  output logic               busy,
  output logic               done,
  output logic               err_tmo
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NCH - 1);
  localparam logic [CH_W-1:0]    CH_ZERO   = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]    CH_ONE    = CH_W'(1);
  localparam logic [ADDR_W-1:0]  NCH_A     = ADDR_W'(NCH);
  localparam logic [TMO_W-1:0]   TMO_MAX   = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0]   TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]   TMO_ONE   = TMO_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PHASE_W-1:0] PH_ZERO   = {PHASE_W{1'b0}};
  localparam logic [PHASE_W-1:0] PH_ONE    = PHASE_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCUM   = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_WAIT_PS = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [NCH-1:0]     cmp_meta_q;
  logic [NCH-1:0]     cmp_s_q;
  logic               start_q;
  logic               start_rise;

  logic [2:0]         state_q,     state_d;
  logic [CNT_W-1:0]   avg_q,       avg_d;
  logic [PHASE_W-1:0] steps_q,     steps_d;
  logic               dir_q,       dir_d;
  logic [CNT_W-1:0]   acc_q [NCH];
  logic [CNT_W-1:0]   acc_d [NCH];
  logic [CNT_W-1:0]   trig_cnt_q,  trig_cnt_d;
  logic [CH_W-1:0]    ch_q,        ch_d;
  logic [PHASE_W-1:0] phase_q,     phase_d;
  logic [TMO_W-1:0]   tmo_q,       tmo_d;
  logic               ps_en_q,     ps_en_d;
  logic               ps_incdec_q, ps_incdec_d;
  logic               wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q,   wr_addr_d;
  logic [CNT_W-1:0]   wr_data_q,   wr_data_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               err_tmo_q,   err_tmo_d;

  assign start_rise = start & ~start_q;

  // Two-flop synchroniser for the asynchronous comparator bits, plus start edge history.
  always_ff @(posedge shifting_clk or negedge S_AXI_DATA_aresetn) begin
    if (!S_AXI_DATA_aresetn) begin
      cmp_meta_q <= {NCH{1'b0}};
      cmp_s_q    <= {NCH{1'b0}};
      start_q    <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_data;
      cmp_s_q    <= cmp_meta_q;
      start_q    <= start;
    end
  end

  // Sweep sequencing: next state, accumulators and look-ahead output values.
  always_comb begin
    state_d     = state_q;
    avg_d       = avg_q;
    steps_d     = steps_q;
    dir_d       = dir_q;
    acc_d       = acc_q;
    trig_cnt_d  = trig_cnt_q;
    ch_d        = ch_q;
    phase_d     = phase_q;
    tmo_d       = tmo_q;
    done_d      = done_q;
    err_tmo_d   = err_tmo_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          avg_d      = (avg_count == CNT_ZERO) ? CNT_ONE : avg_count;
          steps_d    = (phase_steps == PH_ZERO) ? PH_ONE : phase_steps;
          dir_d      = dir;
          for (int c = 0; c < NCH; c++) begin
            acc_d[c] = CNT_ZERO;
          end
          trig_cnt_d = CNT_ZERO;
          ch_d       = CH_ZERO;
          phase_d    = PH_ZERO;
          done_d     = 1'b0;
          err_tmo_d  = 1'b0;
          state_d    = S_ACCUM;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (trig_in) begin
          for (int c = 0; c < NCH; c++) begin
            acc_d[c] = acc_q[c] + {{(CNT_W-1){1'b0}}, cmp_s_q[c]};
          end
          trig_cnt_d = trig_cnt_q + CNT_ONE;
          if (trig_cnt_d == avg_q) begin
            ch_d    = CH_ZERO;
            state_d = S_WRITE;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_WRITE: begin
        if (ch_q == CH_LAST) begin
          for (int c = 0; c < NCH; c++) begin
            acc_d[c] = CNT_ZERO;
          end
          trig_cnt_d = CNT_ZERO;
          ch_d       = CH_ZERO;
          if (phase_q == (steps_q - PH_ONE)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          ch_d    = ch_q + CH_ONE;
          state_d = S_WRITE;
        end
      end
      S_SHIFT: begin
        tmo_d   = TMO_ZERO;
        state_d = S_WAIT_PS;
      end
      S_WAIT_PS: begin
        if (ps_done) begin
          phase_d = phase_q + PH_ONE;
          state_d = S_ACCUM;
        end else if (tmo_q == TMO_MAX) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d   = tmo_q + TMO_ONE;
          state_d = S_WAIT_PS;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every other transition and leaves the status flags untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      phase_d   = phase_q;
      done_d    = done_q;
      err_tmo_d = err_tmo_q;
    end else begin
      state_d   = state_d;
    end

    wr_en_d     = (state_d == S_WRITE);
    ps_en_d     = (state_d == S_SHIFT);
    busy_d      = (state_d != S_IDLE);
    ps_incdec_d = dir_d;
    wr_addr_d   = (ADDR_W'(phase_d) * NCH_A) + ADDR_W'(ch_d);
    if (wr_en_d) begin
      wr_data_d = acc_d[ch_d];
    end else begin
      wr_data_d = CNT_ZERO;
    end
  end

  // State and output registers.
  always_ff @(posedge shifting_clk or negedge S_AXI_DATA_aresetn) begin
    if (!S_AXI_DATA_aresetn) begin
      state_q     <= S_IDLE;
      avg_q       <= CNT_ONE;
      steps_q     <= PH_ONE;
      dir_q       <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc_q[c] <= CNT_ZERO;
      end
      trig_cnt_q  <= CNT_ZERO;
      ch_q        <= CH_ZERO;
      phase_q     <= PH_ZERO;
      tmo_q       <= TMO_ZERO;
      ps_en_q     <= 1'b0;
      ps_incdec_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= CNT_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      avg_q       <= avg_d;
      steps_q     <= steps_d;
      dir_q       <= dir_d;
      acc_q       <= acc_d;
      trig_cnt_q  <= trig_cnt_d;
      ch_q        <= ch_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      ps_en_q     <= ps_en_d;
      ps_incdec_q <= ps_incdec_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign ps_en     = ps_en_q;
  assign ps_incdec = ps_incdec_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign phase_idx = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_ets_multich_sampler.sv
// Self-checking bench for ets_multich_sampler (NCH=4). Per-phase expected
// counts are tallied from the comparator values the bench itself drives.
module tb_ets_multich_sampler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cmp_data = 4'd0;
  logic        trig_in = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] avg_count = 16'd0;
  logic [9:0]  phase_steps = 10'd0;
  logic        ps_done = 1'b0;
  logic        ps_en, ps_incdec, wr_en, busy, done, err_tmo;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [9:0]  phase_idx;

  int checks = 0;
  int errors = 0;
  int ps_cnt = 0;
  bit resp_en = 1'b1;
  logic [11:0] wa_q[$];
  logic [15:0] wd_q[$];

  ets_multich_sampler #(.NCH(4), .CNT_W(16), .PHASE_W(10), .ADDR_W(12), .TMO_W(12)) dut (
    .shifting_clk(clk), .S_AXI_DATA_aresetn(rst_n), .cmp_data(cmp_data),
    .trig_in(trig_in), .start(start), .abort(abort), .dir(dir),
    .avg_count(avg_count), .phase_steps(phase_steps), .ps_en(ps_en),
    .ps_incdec(ps_incdec), .ps_done(ps_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .phase_idx(phase_idx), .busy(busy), .done(done),
    .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  // Log every buffer write and phase-shift request.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (ps_en) ps_cnt++;
  end

  // MMCM stand-in: ps_done five cycles after each ps_en.
  always begin
    @(negedge clk);
    if (ps_en && resp_en) begin
      repeat (5) @(posedge clk);
      #1 ps_done = 1'b1;
      @(posedge clk);
      #1 ps_done = 1'b0;
    end
  end

  task automatic start_sweep(input logic [15:0] a, input logic [9:0] s, input logic d);
    @(posedge clk); #1;
    avg_count = a; phase_steps = s; dir = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_trig(input logic [3:0] cv, input int hold);
    cmp_data = cv;
    repeat (3) @(posedge clk);
    #1 trig_in = 1'b1;
    repeat (hold) @(posedge clk);
    #1 trig_in = 1'b0;
  endtask

  task automatic wait_phase(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int'(phase_idx) == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ps_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ps_en) begin ok = 1'b1; break; end
    end
  endtask

  // mode 0: constant cval, 1: random, 2: random with channel 2 toggling per trigger.
  task automatic run_sweep(input string name, input logic [15:0] a, input logic [9:0] s,
                           input logic d, input int mode, input logic [3:0] cval, input bit extra);
    int avg_e, st_e, wb, pb, n;
    int cnt [4];
    logic [3:0] cv;
    bit ok;
    logic [11:0] ea[$];
    logic [15:0] ed[$];
    avg_e = (a == 16'd0) ? 1 : int'(a);
    st_e  = (s == 10'd0) ? 1 : int'(s);
    wb = wa_q.size();
    pb = ps_cnt;
    start_sweep(a, s, d);
    for (int p = 0; p < st_e; p++) begin
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int k = 0; k < avg_e; k++) begin
        case (mode)
          0: cv = cval;
          1: cv = 4'($urandom_range(0, 15));
          default: begin cv = 4'($urandom_range(0, 15)); cv[2] = k[0]; end
        endcase
        for (int c = 0; c < 4; c++) cnt[c] += int'(cv[c]);
        pulse_trig(cv, (extra && (k == avg_e - 1)) ? 5 : 1);
      end
      for (int c = 0; c < 4; c++) begin
        ea.push_back(12'(p * 4 + c));
        ed.push_back(16'(cnt[c]));
      end
      if (p < st_e - 1) begin
        wait_phase(p + 1, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s phase_advance: phase_idx=%0d expected %0d", name, phase_idx, p + 1);
          return;
        end
      end
    end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s idle: busy=%0b expected 0", name, busy); end
    n = wa_q.size() - wb;
    checks++;
    if (n != ea.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, n, ea.size());
    end
    for (int i = 0; i < ea.size() && i < n; i++) begin
      checks++;
      if (wa_q[wb + i] !== ea[i]) begin
        errors++;
        $display("FAIL %s wr_addr[%0d]: got %0d expected %0d", name, i, wa_q[wb + i], ea[i]);
      end
      checks++;
      if (wd_q[wb + i] !== ed[i]) begin
        errors++;
        $display("FAIL %s wr_data[%0d]: got %0d expected %0d", name, i, wd_q[wb + i], ed[i]);
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %0b expected 1", name, done); end
    checks++;
    if (err_tmo !== 1'b0) begin errors++; $display("FAIL %s err_tmo: got %0b expected 0", name, err_tmo); end
    checks++;
    if (phase_idx !== 10'(st_e - 1)) begin
      errors++;
      $display("FAIL %s final_phase: got %0d expected %0d", name, phase_idx, st_e - 1);
    end
    checks++;
    if (ps_cnt - pb != st_e - 1) begin
      errors++;
      $display("FAIL %s ps_en_count: got %0d expected %0d", name, ps_cnt - pb, st_e - 1);
    end
    checks++;
    if (ps_incdec !== d) begin errors++; $display("FAIL %s ps_incdec: got %0b expected %0b", name, ps_incdec, d); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ps_en, ps_incdec, wr_en, busy, done, err_tmo} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %06b expected 000000", {ps_en, ps_incdec, wr_en, busy, done, err_tmo});
    end
    checks++;
    if (wr_addr !== 12'd0 || wr_data !== 16'd0 || phase_idx !== 10'd0) begin
      errors++;
      $display("FAIL reset_buses: addr=%0d data=%0d phase=%0d expected 0", wr_addr, wr_data, phase_idx);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_basic();
    run_sweep("basic", 16'd8, 10'd3, 1'b1, 0, 4'b0101, 1'b0);
  endtask

  task automatic test_zero_cfg();
    run_sweep("zero_cfg", 16'd0, 10'd0, 1'b0, 1, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      run_sweep("random", 16'($urandom_range(1, 12)), 10'($urandom_range(1, 4)),
                1'($urandom_range(0, 1)), 1, 4'b0000, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_toggle();
    int wb;
    wb = wa_q.size();
    run_sweep("toggle", 16'd100, 10'd2, 1'b1, 2, 4'b0000, 1'b1);
    checks++;
    if (wa_q.size() < wb + 8 || wd_q[wb + 2] !== 16'd50 || wd_q[wb + 6] !== 16'd50) begin
      errors++;
      $display("FAIL toggle_ch2: got %0d expected 50", (wa_q.size() > wb + 2) ? wd_q[wb + 2] : 16'd0);
    end
  endtask

  task automatic test_abort();
    int wb, pb;
    wb = wa_q.size();
    pb = ps_cnt;
    start_sweep(16'd2, 10'd2, 1'b1);
    pulse_trig(4'b0011, 1);
    repeat (3) @(posedge clk);
    #1 trig_in = 1'b1;
    @(posedge clk); #1 trig_in = 1'b0;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    repeat (10) @(negedge clk);
    checks++;
    if (wa_q.size() - wb != 2) begin
      errors++;
      $display("FAIL abort_writes: got %0d expected 2", wa_q.size() - wb);
    end else begin
      checks++;
      if (wa_q[wb] !== 12'd0 || wa_q[wb + 1] !== 12'd1 || wd_q[wb] !== 16'd2 || wd_q[wb + 1] !== 16'd2) begin
        errors++;
        $display("FAIL abort_data: addr %0d,%0d data %0d,%0d expected 0,1 and 2,2",
                 wa_q[wb], wa_q[wb + 1], wd_q[wb], wd_q[wb + 1]);
      end
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b expected 0", done); end
    checks++;
    if (ps_cnt != pb) begin errors++; $display("FAIL abort_ps_en: got %0d expected 0", ps_cnt - pb); end
  endtask

  task automatic test_timeout();
    bit ok;
    resp_en = 1'b0;
    start_sweep(16'd1, 10'd2, 1'b0);
    pulse_trig(4'b1111, 1);
    wait_ps_en(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_ps_en: got 0 expected 1"); end
    repeat (4000) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err_tmo !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: busy=%0b err_tmo=%0b expected 1 and 0", busy, err_tmo);
    end
    wait_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_idle: busy=%0b expected 0", busy); end
    checks++;
    if (err_tmo !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_flags: err_tmo=%0b done=%0b expected 1 and 0", err_tmo, done);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_midwait();
    bit ok;
    resp_en = 1'b0;
    start_sweep(16'd1, 10'd3, 1'b1);
    pulse_trig(4'b1111, 1);
    wait_ps_en(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstw_ps_en: got 0 expected 1"); end
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ps_en, ps_incdec, wr_en, busy, done, err_tmo} !== 6'b0 || phase_idx !== 10'd0 ||
        wr_addr !== 12'd0 || wr_data !== 16'd0) begin
      errors++;
      $display("FAIL rstw_outputs: flags=%06b phase=%0d expected all 0",
               {ps_en, ps_incdec, wr_en, busy, done, err_tmo}, phase_idx);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    resp_en = 1'b1;
    run_sweep("post_reset", 16'd3, 10'd3, 1'b1, 0, 4'b1010, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cfg();
    test_random();
    test_toggle();
    test_abort();
    test_timeout();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
